// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronises rx, centre-samples each bit and hands the
// received byte to the consumer through a rdy/ack handshake, flagging framing errors and overruns.
module uart_receiver #(
  parameter logic [15:0] BIT_RATE_VAL = 16'h01B0
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rdy,
  input  logic       ack,
  output logic       busy,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Half a bit gets the first sample to the start-bit centre; whole bits thereafter.
  localparam logic [15:0] HALF_LOAD = (BIT_RATE_VAL >> 1) - 16'd1;
  localparam logic [15:0] FULL_LOAD = BIT_RATE_VAL - 16'd1;

  state_t      state_r;
  logic        rx_meta_r;
  logic        rx_s_r;
  logic [15:0] cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  dout_r;
  logic        rdy_r;
  logic        busy_r;
  logic        ferr_r;
  logic        ovr_r;

  // Two-flop synchroniser for the asynchronous serial line, idling high
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Receive FSM with bit timing, output handshake and error flags
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      dout_r    <= 8'h00;
      rdy_r     <= 1'b0;
      busy_r    <= 1'b0;
      ferr_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      ferr_r <= 1'b0;
      if (ack && rdy_r) begin
        rdy_r <= 1'b0;
        ovr_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rx_s_r) begin
            cnt_r   <= HALF_LOAD;
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_r == 16'd0) begin
            if (rx_s_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r     <= FULL_LOAD;
              bit_cnt_r <= 3'd0;
              state_r   <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_r == 16'd0) begin
            shift_r <= {rx_s_r, shift_r[7:1]};
            cnt_r   <= FULL_LOAD;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_r == 16'd0) begin
            if (rx_s_r) begin
              // Commit overrides any same-cycle ack: the new byte stays pending.
              dout_r  <= shift_r;
              rdy_r   <= 1'b1;
              if (rdy_r && !ack) begin
                ovr_r <= 1'b1;
              end
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              ferr_r  <= 1'b1;
              state_r <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_BREAK: begin
          if (rx_s_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_r;
  assign rdy  = rdy_r;
  assign busy = busy_r;
  assign ferr = ferr_r;
  assign ovr  = ovr_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: table-driven frames
// plus hand sequences for glitch, framing error, overrun, streaming and reset.
module tb_uart_receiver;

  logic       clk;
  logic       res;
  logic       rx;
  logic [7:0] dout;
  logic       rdy;
  logic       ack;
  logic       busy;
  logic       ferr;
  logic       ovr;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int last_rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic rdy_q = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_rdy;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_receiver #(.BIT_RATE_VAL(16'd16)) dut (
    .clk (clk),
    .res (res),
    .rx  (rx),
    .dout(dout),
    .rdy (rdy),
    .ack (ack),
    .busy(busy),
    .ferr(ferr),
    .ovr (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge: byte arrivals, ferr/ovr activity
  always @(negedge clk) begin
    if (rdy && !rdy_q) begin
      rxq.push_back(dout);
      last_rise_cyc = cyc;
    end
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    rdy_q = rdy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One 10-bit frame, 16 cycles per bit; iteration k follows clock edge k of the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic ack_stop, input logic auto_ack);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(posedge clk); #1;
      if (k == 0) frame_start_cyc = cyc;
      rx = bits[k / 16];
      if (auto_ack) ack = rdy && !ack;
      else ack = ack_stop && (k == 154);
    end
    ack = 1'b0;
  endtask

  task automatic ack_pulse;
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  initial begin
    int f0;
    int o0;
    int base;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1};
    vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[4] = '{8'hC3, 1'b0, 8'hFF, 1'b0, 1};
    vecs[5] = '{8'h7E, 1'b1, 8'h7E, 1'b1, 0};
    vecs[0].exp_ferr = 0;

    res = 1'b0; rx = 1'b1; ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = ~rx;
    end
    rx = 1'b1;
    @(posedge clk); #1 res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovr", ovr, 1'b0);
    check("reset_ferr", ferr, 1'b0);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      if (vecs[i].exp_rdy) begin
        // 2 synchroniser cycles plus 8+9*16+1 from T0.
        check($sformatf("vec%0d_latency", i), last_rise_cyc - frame_start_cyc, 155);
        ack_pulse();
        check($sformatf("vec%0d_ack_clears", i), rdy, 1'b0);
      end
    end

    // Glitch: 5 low cycles then high
    f0 = ferr_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_dout", dout, 8'h7E);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_idle", busy, 1'b0);

    // Framing error followed by a held-low line
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_rdy", rdy, 1'b0);
    check("ferr_break_busy", busy, 1'b1);
    check("ferr_dout_kept", dout, 8'h7E);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("ferr_break_exit", busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("after_ferr_dout", dout, 8'h81);
    check("after_ferr_rdy", rdy, 1'b1);
    ack_pulse();

    // Overrun: two frames, no ack
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ovr_dout", dout, 8'h22);
    check("ovr_rdy", rdy, 1'b1);
    check("ovr_set", ovr, 1'b1);
    ack_pulse();
    check("ovr_cleared", ovr, 1'b0);
    check("ovr_rdy_cleared", rdy, 1'b0);

    // Ack in the stop-sample cycle of the second frame
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("simack_rdy", rdy, 1'b1);
    check("simack_dout", dout, 8'h22);
    check("simack_ovr", ovr, 1'b0);
    ack_pulse();

    // Back-to-back stream with prompt acks
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    base = rxq.size();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      send_frame(b, 1'b1, 1'b0, 1'b1);
    end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stream_count", rxq.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < rxq.size())
        check($sformatf("stream_byte%0d", i), rxq[base + i], expq[i]);
      else
        check($sformatf("stream_byte%0d_missing", i), 32'd0, 32'd1);
    end
    check("stream_ferr", ferr_cnt - f0, 0);
    check("stream_ovr", ovr_cnt - o0, 0);

    // Reset in the middle of a frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midframe_busy", busy, 1'b1);
    res = 1'b0;
    #1;
    check("midframe_reset_busy", busy, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 res = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("midframe_rdy", rdy, 1'b0);
    check("midframe_idle", busy, 1'b0);
    check("midframe_dout", dout, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; consumes the 8N1 line produced by the team's transmit stage (idle high, start 0, 8 data bits LSB first, stop 1).
- Synchronises the asynchronous rx line, centre-samples each bit using the shared BIT_RATE_VAL clocks-per-bit convention, and presents the received byte with a ready/acknowledge handshake.
- Flags framing errors and overruns.

Parameters:
- BIT_RATE_VAL, 16'h01B0, clocks per bit period. Legal range 4..65535. Same value as the paired transmitter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- res  input  1  asynchronous, active-low reset
- rx  input  1  serial line, asynchronous to clk
- dout  output  8  last accepted byte
- rdy  output  1  dout holds an unacknowledged byte
- ack  input  1  consumer acknowledge; clears rdy
- busy  output  1  frame reception in progress (state != IDLE)
- ferr  output  1  one-cycle pulse: stop bit sampled low
- ovr  output  1  sticky: byte accepted while rdy was already 1

Behaviour:
- Reset (res=0, takes effect immediately, no clock needed):
  - state=IDLE; dout=8'h00; rdy=0; ferr=0; ovr=0; busy=0.
  - Both synchroniser flops preset to 1; bit counter and clock counter cleared.
  - Reset mid-frame abandons the frame; nothing is committed.
- Synchroniser: 2 flops; rx_s = second flop. All decisions use rx_s only. Latency from the rx pin to rx_s is 2 cycles.
- Clock counter: 16 bits, loaded then decremented by 1 per cycle. A sample is taken in the cycle the counter reads 0.
- States:
  - IDLE: on rx_s==0, load counter with (BIT_RATE_VAL>>1)-1 and go to START. Call this cycle T0.
  - START: at count 0, sample rx_s.
    - If 1: glitch. Return to IDLE; no outputs change.
    - If 0: load BIT_RATE_VAL-1, bit count=0, go to DATA.
  - DATA: at count 0, shift rx_s into the MSB of the 8-bit shift register (right shift, so the LSB-first byte assembles correctly).
    - Bit count 0..6: increment bit count, reload BIT_RATE_VAL-1.
    - Bit count 7: reload BIT_RATE_VAL-1 and go to STOP.
  - STOP: at count 0, sample rx_s.
    - If 1: commit (see below) and go to IDLE.
    - If 0: assert ferr for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from being read as a new start bit.
- Sample instants relative to T0:
  - start bit at T0+(BIT_RATE_VAL>>1)
  - data bit i at T0+(BIT_RATE_VAL>>1)+(i+1)*BIT_RATE_VAL
  - stop bit at T0+(BIT_RATE_VAL>>1)+9*BIT_RATE_VAL
- Return to IDLE at stop-bit centre. A start edge in the second half of the stop bit is therefore accepted; back-to-back frames are received with no gap.
- Commit, in the cycle after the stop sample:
  - dout <= shift register; rdy <= 1.
  - If rdy was 1 and ack is not asserted in the stop-sample cycle, ovr <= 1. The old byte is overwritten.
- Handshake:
  - ack=1 while rdy=1 clears rdy in the next cycle and clears ovr.
  - ack while rdy=0 has no effect.
  - ack in the same cycle as a commit: the commit wins, so rdy stays 1 with the new byte, and ovr is not set.
- dout is stable whenever rdy=1 and no commit occurs.
- busy=1 in START, DATA, STOP and BREAK.
- The counter never wraps: it is always reloaded before it can decrement past 0.

Test Plan:
- Setup for all scenarios: BIT_RATE_VAL=16, ack=0 unless stated.
- Reset: hold res=0 with rx toggling, then release → dout=00, rdy=0, busy=0, ovr=0, ferr=0. Drive res=0 in the middle of a frame → busy drops immediately; rdy stays 0 after release.
- Single byte: send 8'hA5 with a clean frame → rdy rises exactly 8+9*16+1 cycles after T0; dout=A5; ferr=0. Pulse ack for 1 cycle → rdy=0 on the next cycle.
- Glitch: rx low for 5 cycles, then high → START sample reads 1, back to IDLE; rdy, dout and ferr unchanged.
- Framing error: send 8'h3C with stop bit 0, then hold rx low for 40 cycles → ferr is a 1-cycle pulse; rdy=0; busy stays 1 (BREAK) until rx returns high. A following good frame 8'h81 gives dout=81.
- Overrun and simultaneous ack:
  - Send 8'h11 then 8'h22 back-to-back with no ack → dout=22, rdy=1, ovr=1.
  - Ack → ovr=0.
  - Repeat with ack asserted in the stop-sample cycle of the second frame → rdy=1, dout=22, ovr=0.
- Back-to-back stream: send 16 random bytes with zero gap, acking each byte within 10 cycles → every byte is received in order, ferr and ovr never asserted.
